// File: rtl/fft_stream_adapter.sv
// ---------------------------------------------------------------------------
// fft_stream_adapter
//
// Takes loosely framed Avalon-ST input packets and turns them into frames of
// exactly FFT_LENGTH beats for the FFT core sink.
//   - Short packets are padded with zero samples up to FFT_LENGTH beats.
//   - Beats of a long packet beyond FFT_LENGTH are accepted and discarded.
//   - Beats that arrive outside a packet are discarded.
// Each output beat carries the sample in [W:1] and the frame's inverse-FFT
// flag in bit [0]. That flag is latched on the frame's sop beat.
// A two-entry skid buffer keeps the output registered and still allows one
// beat per cycle.
//
// Ports
//   clock_clk, reset_reset         clock; asynchronous active-high reset
//   inverse_fft                    mode select, latched on an accepted sop
//   stat_clear                     pulse, clears the sticky status flags
//   asi_in_*                       Avalon-ST sink (ready latency 0)
//   aso_out_*                      Avalon-ST source (ready latency 0)
//   stat_short/long/orphan         sticky: padded / truncated / orphan or
//                                  mid-packet sop seen
//
// FSM states
//   state  | meaning
//   IDLE   | between frames; waiting for an input sop, other beats dropped
//   PASS   | copying input beats into the current frame
//   PAD    | input ended early; writing zero beats until the frame is full
//   DROP   | frame full; discarding input until the packet's eop
// ---------------------------------------------------------------------------
module fft_stream_adapter #(
    parameter int INPUT_SYMBOL_WIDTH = 32,
    parameter int FFT_LENGTH         = 1024
) (
    input  logic                          clock_clk,
    input  logic                          reset_reset,
    input  logic                          inverse_fft,
    input  logic                          stat_clear,
    input  logic [INPUT_SYMBOL_WIDTH-1:0] asi_in_data,
    input  logic                          asi_in_valid,
    input  logic                          asi_in_startofpacket,
    input  logic                          asi_in_endofpacket,
    output logic                          asi_in_ready,
    output logic [INPUT_SYMBOL_WIDTH:0]   aso_out_data,
    output logic                          aso_out_valid,
    output logic                          aso_out_startofpacket,
    output logic                          aso_out_endofpacket,
    input  logic                          aso_out_ready,
    output logic                          stat_short,
    output logic                          stat_long,
    output logic                          stat_orphan
);

    localparam int W      = INPUT_SYMBOL_WIDTH;
    localparam int CNT_W  = $clog2(FFT_LENGTH);
    // Skid entry layout: {sample, flag, sop, eop}
    localparam int BEAT_W = W + 3;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FFT_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_PAD  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               inv_lat_q, inv_lat_d;
    logic               dropped_q, dropped_d;
    logic               run_q;

    logic [BEAT_W-1:0]  ent0_q, ent0_d;
    logic [BEAT_W-1:0]  ent1_q, ent1_d;
    logic               vld0_q, vld0_d;
    logic               vld1_q, vld1_d;

    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               orphan_q, orphan_d;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic               full;
    logic               rd_en;
    logic               in_ready;
    logic               in_acc;
    logic               at_last;
    logic               wr_en;
    logic [W:0]         wr_data;
    logic               wr_sop;
    logic               wr_eop;
    logic [BEAT_W-1:0]  wr_beat;
    logic               set_short;
    logic               set_long;
    logic               set_orphan;

    assign full    = vld1_q;
    assign rd_en   = vld0_q & aso_out_ready;
    assign in_acc  = asi_in_valid & in_ready;
    assign at_last = (beat_cnt_q == LAST_BEAT);
    assign wr_beat = {wr_data, wr_sop, wr_eop};

    // -----------------------------------------------------------------------
    // Framing FSM: next state, skid write request, status set events
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        inv_lat_d  = inv_lat_q;
        dropped_d  = dropped_q;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        wr_sop     = 1'b0;
        wr_eop     = 1'b0;
        set_short  = 1'b0;
        set_long   = 1'b0;
        set_orphan = 1'b0;

        case (state_q)
            S_IDLE: begin
                // run_q holds ready low until the first edge after reset release
                in_ready = run_q & ~full;
                if (in_acc) begin
                    if (asi_in_startofpacket) begin
                        inv_lat_d  = inverse_fft;
                        wr_en      = 1'b1;
                        wr_data    = {asi_in_data, inverse_fft};
                        wr_sop     = 1'b1;
                        beat_cnt_d = CNT_W'(1);
                        if (asi_in_endofpacket) begin
                            state_d   = S_PAD;
                            set_short = 1'b1;
                        end else begin
                            state_d = S_PASS;
                        end
                    end else begin
                        set_orphan = 1'b1;
                    end
                end
            end

            S_PASS: begin
                in_ready = run_q & ~full;
                if (in_acc) begin
                    wr_en      = 1'b1;
                    wr_data    = {asi_in_data, inv_lat_q};
                    wr_eop     = at_last;
                    // Wraps to zero after the last beat, ready for the next frame
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (asi_in_startofpacket) begin
                        set_orphan = 1'b1;
                    end
                    if (at_last) begin
                        if (asi_in_endofpacket) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DROP;
                            dropped_d = 1'b0;
                        end
                    end else if (asi_in_endofpacket) begin
                        state_d   = S_PAD;
                        set_short = 1'b1;
                    end
                end
            end

            S_PAD: begin
                if (!full) begin
                    wr_en      = 1'b1;
                    wr_data    = {{W{1'b0}}, inv_lat_q};
                    wr_eop     = at_last;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (at_last) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DROP: begin
                in_ready = run_q;
                if (in_acc) begin
                    // Only the first discarded beat raises stat_long, so a clear
                    // during a long tail is not immediately undone.
                    if (!dropped_q) begin
                        set_long  = 1'b1;
                        dropped_d = 1'b1;
                    end
                    if (asi_in_startofpacket) begin
                        set_orphan = 1'b1;
                    end
                    if (asi_in_endofpacket) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Skid buffer next state. Entry 0 always holds the oldest beat and drives
    // the outputs; entry 1 only fills when entry 0 is stalled. No write is
    // requested while both entries are full.
    // -----------------------------------------------------------------------
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld0_d = vld0_q;
        vld1_d = vld1_q;

        if (vld1_q) begin
            if (rd_en) begin
                ent0_d = ent1_q;
                vld1_d = 1'b0;
            end
        end else if (vld0_q) begin
            if (rd_en && wr_en) begin
                ent0_d = wr_beat;
            end else if (rd_en) begin
                vld0_d = 1'b0;
            end else if (wr_en) begin
                ent1_d = wr_beat;
                vld1_d = 1'b1;
            end
        end else if (wr_en) begin
            ent0_d = wr_beat;
            vld0_d = 1'b1;
        end
    end

    // A set event in the same cycle as a clear keeps the flag set.
    always_comb begin
        short_d  = set_short  | (short_q  & ~stat_clear);
        long_d   = set_long   | (long_q   & ~stat_clear);
        orphan_d = set_orphan | (orphan_q & ~stat_clear);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            inv_lat_q  <= 1'b0;
            dropped_q  <= 1'b0;
            run_q      <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            inv_lat_q  <= inv_lat_d;
            dropped_q  <= dropped_d;
            run_q      <= 1'b1;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            short_q    <= short_d;
            long_q     <= long_d;
            orphan_q   <= orphan_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign asi_in_ready          = in_ready;
    assign aso_out_valid         = vld0_q;
    assign aso_out_data          = ent0_q[BEAT_W-1:2];
    assign aso_out_startofpacket = ent0_q[1];
    assign aso_out_endofpacket   = ent0_q[0];
    assign stat_short            = short_q;
    assign stat_long             = long_q;
    assign stat_orphan           = orphan_q;

endmodule
